conv_mac_engine: RTL and testbench

//  Pipelined multi-channel KxK convolution MAC with valid/ready flow control.

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_adder_tree.sv | 37 +++
 rtl/conv_mac_engine.sv | 190 +++++++++++++++++++
 tb/tb_conv_mac_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK convolution MAC engine.
// Holds the engine state enum, beat/tap-offset helpers and the output shift/saturate function.
// Build option: CONV_RELU_EN clamps negative results to zero before saturation.
package conv_pkg;

    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        IDLE     = 2'd1,
        ACCUM    = 2'd2
    } convState_t;

    // Beats needed to cover every channel of one output pixel.
    function automatic int nBeats(input int d, input int rate);
        return d / rate;
    endfunction

    // Bit offset of tap 'tap' of lane 'lane' inside the packed pixel bus.
    function automatic int tapOffset(input int lane, input int tap, input int k, input int dataWidth);
        return (lane * k * k + tap) * dataWidth;
    endfunction

    // Floor-shift the accumulator to pixel scale, then clamp to the signed pixel range.
    function automatic logic [63:0] shiftSaturate(input logic signed [63:0] acc,
                                                  input int fracBits,
                                                  input int dataWidth);
        logic signed [63:0] shifted;
        logic signed [63:0] maxVal;
        logic signed [63:0] minVal;
        shifted = acc >>> fracBits;
`ifdef CONV_RELU_EN
        if (shifted < 64'sd0) begin
            shifted = 64'sd0;
        end
`endif
        maxVal = (64'sd1 <<< (dataWidth - 1)) - 64'sd1;
        minVal = -(64'sd1 <<< (dataWidth - 1));
        if (shifted > maxVal) begin
            return maxVal;
        end else if (shifted < minVal) begin
            return minVal;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Reduces NumIn signed products to one sign-extended sum.
// Latency: 1 cycle (combinational reduction, single output register).
// Backpressure: i_en low freezes the output register.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int NumIn    = 9,
    parameter int InWidth  = 32,
    parameter int OutWidth = 40
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [NumIn*InWidth-1:0]      i_products,
    output logic signed [OutWidth-1:0]    o_sum
);

    logic signed [OutWidth-1:0] sumComb;

    // Flat sign-extended sum; synthesis rebalances the chain into a tree.
    always_comb begin
        sumComb = '0;
        for (int i = 0; i < NumIn; i++) begin
            sumComb = sumComb + OutWidth'($signed(i_products[i*InWidth +: InWidth]));
        end
    end

    // Single output register, held while the pipeline is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sum <= '0;
        end else if (i_en) begin
            o_sum <= sumComb;
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-channel KxK convolution MAC: D channels accumulated over D/InputRate beats per output pixel.
// Latency: result valid 3 cycles after the last beat of a group is accepted; back-to-back groups, no bubble.
// Backpressure: a held, unaccepted result freezes the whole pipeline and drops o_pixel_data_ready. Option: CONV_RELU_EN.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int InputRate = 1,
    parameter int D         = 2,
    parameter int K         = 3,
    parameter int FracBits  = 8,
    parameter int AccWidth  = 2*DataWidth+8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_kernel_wr,
    input  logic [$clog2(D*K*K)-1:0]           i_kernel_addr,
    input  logic [DataWidth-1:0]               i_kernel_data,
    input  logic                               i_kernel_commit,
    input  logic [InputRate*K*K*DataWidth-1:0] i_pixel_data,
    input  logic                               i_pixel_data_valid,
    output logic                               o_pixel_data_ready,
    output logic [DataWidth-1:0]               o_convolved_data,
    output logic                               o_convolved_data_valid,
    input  logic                               i_convolved_data_ready,
    output logic                               o_busy
);

    localparam int KK       = K * K;
    localparam int NumTaps  = InputRate * KK;
    localparam int KWords   = D * KK;
    localparam int NBEATS   = nBeats(D, InputRate);
    localparam int CntW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int ProdW    = 2 * DataWidth;

    if (D % InputRate != 0) begin : gBadRate
        $error("conv_mac_engine: D must be a multiple of InputRate");
    end

    convState_t state, nextState;

    logic [CntW-1:0]              beatCnt;
    logic                         stall;
    logic                         accept;
    logic                         lastBeat;
    logic                         kernelWrEn;
    logic signed [DataWidth-1:0]  kernelMem [KWords];
    logic signed [ProdW-1:0]      prodNext [NumTaps];
    logic [NumTaps*ProdW-1:0]     prodReg;
    logic                         s1Vld, s1First, s1Last;
    logic                         s2Vld, s2First, s2Last;
    logic                         s3Done;
    logic signed [AccWidth-1:0]   treeSum;
    logic signed [AccWidth-1:0]   accReg;
    logic [DataWidth-1:0]         satData;

    assign stall              = o_convolved_data_valid & ~i_convolved_data_ready;
    assign o_pixel_data_ready = (state != UNLOADED) & ~stall;
    assign accept             = i_pixel_data_valid & o_pixel_data_ready;
    assign lastBeat           = (beatCnt == CntW'(NBEATS - 1));
    assign o_busy             = (state == ACCUM) | s1Vld | s2Vld | s3Done | o_convolved_data_valid;
    assign kernelWrEn         = i_kernel_wr
                              & ((state == UNLOADED) | ((state == IDLE) & ~o_busy))
                              & (32'(i_kernel_addr) < KWords);
    assign satData            = DataWidth'(shiftSaturate(64'(accReg), FracBits, DataWidth));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= UNLOADED;
        end else begin
            state <= nextState;
        end
    end

    // Next state: commit unlocks the datapath, the last beat of a group returns to IDLE.
    always_comb begin
        nextState = state;
        unique case (state)
            UNLOADED: if (i_kernel_commit) nextState = IDLE;
            IDLE:     if (accept && NBEATS > 1) nextState = ACCUM;
            ACCUM:    if (accept && lastBeat) nextState = IDLE;
            default:  nextState = UNLOADED;
        endcase
    end

    // Beat index within the current group; only advances on an accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beatCnt <= '0;
        end else if (accept) begin
            beatCnt <= lastBeat ? '0 : beatCnt + CntW'(1);
        end
    end

    // Kernel word storage; writes outside an idle window are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < KWords; i++) begin
                kernelMem[i] <= '0;
            end
        end else if (kernelWrEn) begin
            kernelMem[i_kernel_addr] <= i_kernel_data;
        end
    end

    // Per-tap products; lane c of beat g multiplies against kernel channel g*InputRate+c.
    always_comb begin
        for (int i = 0; i < NumTaps; i++) begin
            prodNext[i] = '0;
        end
        for (int c = 0; c < InputRate; c++) begin
            for (int t = 0; t < KK; t++) begin
                prodNext[c*KK + t] = $signed(i_pixel_data[tapOffset(c, t, K, DataWidth) +: DataWidth])
                                   * kernelMem[(int'(beatCnt) * InputRate + c) * KK + t];
            end
        end
    end

    // Stage 1: product register plus group-position flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1Vld   <= 1'b0;
            s1First <= 1'b0;
            s1Last  <= 1'b0;
            prodReg <= '0;
        end else if (!stall) begin
            s1Vld   <= accept;
            s1First <= (beatCnt == '0);
            s1Last  <= lastBeat;
            if (accept) begin
                for (int i = 0; i < NumTaps; i++) begin
                    prodReg[i*ProdW +: ProdW] <= prodNext[i];
                end
            end
        end
    end

    conv_adder_tree #(
        .NumIn    (NumTaps),
        .InWidth  (ProdW),
        .OutWidth (AccWidth)
    ) uAdderTree (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (~stall),
        .i_products (prodReg),
        .o_sum      (treeSum)
    );

    // Stage 2: flags travelling alongside the adder-tree register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2Vld   <= 1'b0;
            s2First <= 1'b0;
            s2Last  <= 1'b0;
        end else if (!stall) begin
            s2Vld   <= s1Vld;
            s2First <= s1First;
            s2Last  <= s1Last;
        end
    end

    // Stage 3: accumulator restarts on the first beat of a group.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            accReg <= '0;
            s3Done <= 1'b0;
        end else if (!stall) begin
            s3Done <= s2Vld & s2Last;
            if (s2Vld) begin
                accReg <= s2First ? treeSum : accReg + treeSum;
            end
        end
    end

    // Output register: holds value and valid until the downstream handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_convolved_data       <= '0;
            o_convolved_data_valid <= 1'b0;
        end else if (!stall) begin
            o_convolved_data_valid <= s3Done;
            if (s3Done) begin
                o_convolved_data <= satData;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized bench for conv_mac_engine against a plain-arithmetic reference model.
// Two instances share all inputs: FracBits=0 and FracBits=8, each checked against its own expected value.
// Downstream ready is either forced or randomized to exercise stalls.
module tb_conv_mac_engine;

    localparam int DW = 16;
    localparam int R  = 1;
    localparam int D  = 2;
    localparam int K  = 3;
    localparam int KK = K * K;
    localparam int NW = D * KK;
    localparam int AW = $clog2(NW);
    localparam int PW = R * KK * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          kWr;
    logic [AW-1:0] kAddr;
    logic [DW-1:0] kData;
    logic          kCommit;
    logic [PW-1:0] pixData;
    logic          pixVld;
    logic          pixRdyA, pixRdyB;
    logic [DW-1:0] outA, outB;
    logic          outVldA, outVldB;
    logic          outRdy;
    logic          busyA, busyB;

    int            checks = 0;
    int            errors = 0;
    longint        kref [NW];
    logic [DW-1:0] qA [$];
    logic [DW-1:0] qB [$];
    logic [DW-1:0] expA, expB;
    bit            randReady = 1'b0;
    bit            forcedReady = 1'b1;
    bit            senderDone;

    always #5 clk = ~clk;

    conv_mac_engine #(.DataWidth(DW), .InputRate(R), .D(D), .K(K), .FracBits(0)) dutA (
        .i_clk(clk), .i_rst(rst), .i_kernel_wr(kWr), .i_kernel_addr(kAddr), .i_kernel_data(kData),
        .i_kernel_commit(kCommit), .i_pixel_data(pixData), .i_pixel_data_valid(pixVld),
        .o_pixel_data_ready(pixRdyA), .o_convolved_data(outA), .o_convolved_data_valid(outVldA),
        .i_convolved_data_ready(outRdy), .o_busy(busyA));

    conv_mac_engine #(.DataWidth(DW), .InputRate(R), .D(D), .K(K), .FracBits(8)) dutB (
        .i_clk(clk), .i_rst(rst), .i_kernel_wr(kWr), .i_kernel_addr(kAddr), .i_kernel_data(kData),
        .i_kernel_commit(kCommit), .i_pixel_data(pixData), .i_pixel_data_valid(pixVld),
        .o_pixel_data_ready(pixRdyB), .o_convolved_data(outB), .o_convolved_data_valid(outVldB),
        .i_convolved_data_ready(outRdy), .o_busy(busyB));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: floor shift, optional ReLU, clamp to signed 16-bit.
    function automatic logic [DW-1:0] refPix(input longint acc, input int frac);
        longint v;
        v = acc >>> frac;
`ifdef CONV_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[DW-1:0];
    endfunction

    function automatic int rv();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    function automatic logic [PW-1:0] packBeat(input int taps [KK]);
        logic [PW-1:0] d;
        d = '0;
        for (int t = 0; t < KK; t++) d[t*DW +: DW] = 16'(taps[t]);
        return d;
    endfunction

    // Downstream ready driver: forced level or random toggling.
    initial begin
        outRdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            outRdy = randReady ? ($urandom_range(0, 2) != 0) : forcedReady;
        end
    end

    // Output monitor: every handshake is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && outVldA && outRdy) begin
            if (qA.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                expA = qA.pop_front();
                expB = qB.pop_front();
                chk("outA", longint'(outA), longint'(expA));
                chk("outB", longint'(outB), longint'(expB));
                chk("vldB", longint'(outVldB), 1);
            end
        end
    end

    task automatic sendBeat(input logic [PW-1:0] d);
        int n;
        bit got;
        pixData = d;
        pixVld  = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 2000) begin
            @(negedge clk);
            if (pixRdyA) got = 1'b1;
            else n++;
        end
        if (!got) chk("beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        pixVld = 1'b0;
    endtask

    task automatic sendGroup(input int taps [D][KK]);
        longint acc;
        int beat [KK];
        acc = 0;
        for (int g = 0; g < D; g++)
            for (int t = 0; t < KK; t++)
                acc += longint'(taps[g][t]) * kref[g*KK + t];
        for (int g = 0; g < D; g++) begin
            for (int t = 0; t < KK; t++) beat[t] = taps[g][t];
            sendBeat(packBeat(beat));
        end
        qA.push_back(refPix(acc, 0));
        qB.push_back(refPix(acc, 8));
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busyA || qA.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 1, 0);
    endtask

    task automatic writeWords(input int vals [NW]);
        for (int i = 0; i < NW; i++) begin
            kWr   = 1'b1;
            kAddr = AW'(i);
            kData = 16'(vals[i]);
            @(posedge clk);
            #1;
        end
        kWr = 1'b0;
    endtask

    task automatic commit();
        kCommit = 1'b1;
        @(posedge clk);
        #1;
        kCommit = 1'b0;
    endtask

    task automatic loadKernel(input int vals [NW]);
        waitIdle();
        writeWords(vals);
        commit();
        for (int i = 0; i < NW; i++) kref[i] = longint'(vals[i]);
    endtask

    task automatic constTaps(output int taps [D][KK], input int v);
        for (int g = 0; g < D; g++) for (int t = 0; t < KK; t++) taps[g][t] = v;
    endtask

    task automatic randTaps(output int taps [D][KK]);
        for (int g = 0; g < D; g++) for (int t = 0; t < KK; t++) taps[g][t] = rv();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv [NW];
        int tp [D][KK];
        int beat [KK];
        longint acc;

        rst = 1'b1; kWr = 1'b0; kAddr = '0; kData = '0; kCommit = 1'b0;
        pixData = '0; pixVld = 1'b0;
        for (int i = 0; i < NW; i++) kref[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", longint'(pixRdyA), 0);
        chk("rst_valid", longint'(outVldA), 0);
        chk("rst_data", longint'(outA), 0);
        chk("rst_busy", longint'(busyA), 0);
        rst = 1'b0;

        // Pixel ready must stay low before the first commit even with a beat offered.
        for (int i = 0; i < NW; i++) kv[i] = 1;
        pixVld = 1'b1;
        pixData = '1;
        writeWords(kv);
        chk("precommit_ready", longint'(pixRdyA), 0);
        chk("precommit_busy", longint'(busyA), 0);
        pixVld = 1'b0;
        commit();
        for (int i = 0; i < NW; i++) kref[i] = 1;

        // Basic: all-ones kernel, taps 2, with latency check.
        constTaps(tp, 2);
        sendGroup(tp);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_n2_valid", longint'(outVldA), 0);
        @(posedge clk); #1;
        chk("lat_n3_valid", longint'(outVldA), 1);
        chk("basic_36", longint'(outA), 36);
        waitIdle();

        // Commit in IDLE changes nothing.
        commit();
        chk("idle_commit_ready", longint'(pixRdyA), 1);
        randTaps(tp);
        sendGroup(tp);
        waitIdle();

        // Backpressure over three back-to-back groups.
        forcedReady = 1'b0;
        senderDone = 1'b0;
        fork
            begin
                int t3 [D][KK];
                for (int j = 0; j < 3; j++) begin
                    randTaps(t3);
                    sendGroup(t3);
                end
                senderDone = 1'b1;
            end
        join_none
        repeat (25) @(posedge clk);
        #1;
        chk("bp_ready_low", longint'(pixRdyA), 0);
        chk("bp_valid_held", longint'(outVldA), 1);
        chk("bp_head_a", longint'(outA), longint'(qA[0]));
        repeat (7) @(posedge clk);
        #1;
        chk("bp_head_stable", longint'(outA), longint'(qA[0]));
        forcedReady = 1'b1;
        for (int n = 0; n < 2000 && !senderDone; n++) @(posedge clk);
        chk("bp_sender_done", longint'(senderDone), 1);
        waitIdle();
        chk("bp_all_drained", longint'(qA.size()), 0);

        // Saturation both directions.
        for (int i = 0; i < NW; i++) kv[i] = 32'h7FFF;
        loadKernel(kv);
        constTaps(tp, 32'h7FFF);
        sendGroup(tp);
        constTaps(tp, -32767);
        sendGroup(tp);
        waitIdle();

        // Fixed-point: 1.0 kernel, 1.5 taps.
        for (int i = 0; i < NW; i++) kv[i] = 32'h0100;
        loadKernel(kv);
        constTaps(tp, 32'h0180);
        sendGroup(tp);
        waitIdle();

        // Reset mid-group.
        for (int i = 0; i < NW; i++) kv[i] = rv();
        loadKernel(kv);
        randTaps(tp);
        for (int t = 0; t < KK; t++) beat[t] = tp[0][t];
        sendBeat(packBeat(beat));
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NW; i++) kref[i] = 0;
        chk("midrst_valid", longint'(outVldA), 0);
        chk("midrst_data", longint'(outA), 0);
        chk("midrst_busy", longint'(busyA), 0);
        pixVld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_ready", longint'(pixRdyA), 0);
        pixVld = 1'b0;
        for (int i = 0; i < NW; i++) kv[i] = rv();
        loadKernel(kv);
        randTaps(tp);
        sendGroup(tp);
        waitIdle();

        // Kernel write while busy is ignored.
        randTaps(tp);
        acc = 0;
        for (int g = 0; g < D; g++)
            for (int t = 0; t < KK; t++) acc += longint'(tp[g][t]) * kref[g*KK + t];
        for (int t = 0; t < KK; t++) beat[t] = tp[0][t];
        sendBeat(packBeat(beat));
        chk("busy_mid_group", longint'(busyA), 1);
        for (int i = 0; i < NW; i++) kv[i] = rv();
        writeWords(kv);
        for (int t = 0; t < KK; t++) beat[t] = tp[1][t];
        sendBeat(packBeat(beat));
        qA.push_back(refPix(acc, 0));
        qB.push_back(refPix(acc, 8));
        randTaps(tp);
        sendGroup(tp);
        waitIdle();

        // Random traffic with random downstream ready.
        randReady = 1'b1;
        for (int r = 0; r < 40; r++) begin
            if (r % 10 == 0) begin
                for (int i = 0; i < NW; i++) kv[i] = rv();
                loadKernel(kv);
            end
            randTaps(tp);
            sendGroup(tp);
        end
        waitIdle();
        randReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("end_busyB", longint'(busyB), 0);
        chk("end_validB", longint'(outVldB), 0);
        chk("end_readyB", longint'(pixRdyB), 1);
        chk("end_queue", longint'(qA.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
